rr_mux: RTL and testbench
=========================

# rr_mux

Parametrised N-input, WIDTH-bit registered selector with round-robin arbitration and a valid/ready output handshake. It replaces fixed, select-driven muxes wherever several producers share one downstream consumer, for example multiple counter or display sources feeding a single output path. Unlike a combinational mux, it chooses the channel itself, holds the chosen word until the consumer accepts it, and tells each producer when its word has been taken.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `N`, 4, number of input channels (2..16)
- `SW`, `$clog2(N)`, select/index width (derived; not overridden)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `d`  in  N*WIDTH  packed channel data; channel i occupies `d[i*WIDTH +: WIDTH]`
- `v`  in  N  per-channel valid; producer holds `v[i]` and its data stable until `taken[i]`
- `taken`  out  N  one-hot pulse: channel i captured this cycle
- `y`  out  WIDTH  registered output data
- `y_vld`  out  1  `y` holds an unconsumed word
- `y_sel`  out  SW  index of the channel that `y` came from
- `y_rdy`  in  1  consumer accepts `y` when `y_vld & y_rdy`

Reset is synchronous and active-high: `reset` is sampled on the rising edge of `clk`.

## Operation
- State:
  - output register (`y`, `y_sel`, `y_vld`)
  - round-robin pointer `ptr` [SW-1:0], the highest-priority channel for the next grant
- `load = ~reset & (|v) & (~y_vld | y_rdy)`.
- Grant:
  - Scan channels `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - The first channel with `v` set wins (`gnt`).
- When `load` is set:
  - at the next edge, `y ← d[gnt]`, `y_sel ← gnt`, `y_vld ← 1`
  - `ptr ← (gnt == N-1) ? 0 : gnt+1`; wraps modulo N, including non-power-of-2 N
- Otherwise:
  - if `y_vld & y_rdy`, then `y_vld ← 0`; `y` and `y_sel` keep their last values
  - `ptr` is unchanged
- `taken = load ? onehot(gnt) : 0`. It is combinational, asserted in the same cycle the capture edge occurs.
- Simultaneous consume and new request (`y_vld & y_rdy & |v`): load the new word; `y_vld` stays 1. No bubble.
- Output full (`y_vld & ~y_rdy`): no grant, all `taken` = 0, and `y`/`y_sel` are held stable.
- No request: `ptr` does not advance, so an idle bus does not rotate priority.
- Fairness: with all N channels valid continuously and `y_rdy` = 1, each channel is granted exactly once per N cycles.

## Timing
- Reset values:
  - `y` = 0, `y_sel` = 0, `y_vld` = 0, `ptr` = 0
  - `taken` = 0 while `reset` is high
- Latency: `taken[i]` in cycle t, then `y`/`y_vld` valid from cycle t+1.
- Throughput: 1 word per cycle while `y_rdy` = 1.
- `y_rdy` may be asserted or deasserted in any cycle. `y` must not change while `y_vld & ~y_rdy`.
- Reset mid-transfer: any unconsumed word is dropped (`y_vld` → 0) and `ptr` → 0. No `taken` pulse occurs in the reset cycle, so producers keep their requests.
- Combinational paths:
  - `v` → `taken`
  - `y_rdy` → `taken`
  - no combinational path from `d` to `y`

## Configuration
- `RR_MUX_FORCE_EN` defined:
  - adds ports `force_en` (in, 1) and `force_sel` (in, SW)
  - when `force_en` = 1, the grant is `force_sel` only if `v[force_sel]` = 1; otherwise no grant (`load` = 0)
  - `ptr` is not updated by forced grants
  - `force_sel` ≥ N is treated as no grant
- `RR_MUX_FORCE_EN` undefined: the ports are absent and arbitration is pure round-robin.

## Test plan
- Reset with all `v` = 1:
  - while `reset` = 1: `y_vld` = 0, `taken` = 0
  - first cycle after release: `taken` = 0001
  - next cycle: `y_vld` = 1, `y_sel` = 0
- N=4, all `v` = 1, `y_rdy` = 1, data = {0x44, 0x33, 0x22, 0x11} for channels 3..0: `y_sel` sequence 0,1,2,3,0 and `y` sequence 0x11, 0x22, 0x33, 0x44, 0x11, with `y_vld` held at 1.
- Backpressure: `y_rdy` = 0 for 3 cycles with `y_vld` = 1 → `y`/`y_sel` stable and `taken` = 0 throughout; `y_rdy` = 1 → the next grant goes to channel `ptr`.
- Wrap and sparse requests, N=3: only `v[2]` and `v[0]` set → grants 2, 0, 2; `ptr` wraps from 2 to 0 with no extra cycle.
- Reset mid-transfer: `y_vld` = 1, `y_rdy` = 0, assert `reset` for 1 cycle → `y_vld` = 0, `ptr` = 0, `y` = 0, and the held requests are regranted from channel 0.
- `RR_MUX_FORCE_EN`, `force_en` = 1, `force_sel` = 2, `v` = 1111, `y_rdy` = 1 → `y_sel` = 2 every cycle; then `force_en` = 0 → the next grant follows the untouched `ptr`.

Source files
------------

// File: rtl/rr_mux.sv
// rr_mux: N-input, WIDTH-bit registered selector with round-robin arbitration
// and a valid/ready output handshake. The arbiter picks the channel itself,
// holds the captured word until the consumer accepts it, and pulses taken[i]
// to tell producer i its word has been captured.
//
// Optional feature: define RR_MUX_FORCE_EN to add force_en/force_sel ports that
// override the round-robin choice with a fixed channel (no pointer update).
module rr_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [N-1:0]       v,
`ifdef RR_MUX_FORCE_EN
  input  logic               force_en,
  input  logic [SW-1:0]      force_sel,
`endif
  output logic [N-1:0]       taken,
  output logic [WIDTH-1:0]   y,
  output logic               y_vld,
  output logic [SW-1:0]      y_sel,
  input  logic               y_rdy
);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    gnt;
  logic [SW-1:0]    ptr_nxt;
  logic             gnt_vld;
  logic             forced;
  logic             load;
  logic [WIDTH-1:0] gnt_data;

  // Grant selection: first valid channel scanning from ptr upward with wrap.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = |v;
    forced  = 1'b0;
    idx     = 0;
    // Walk the scan order backwards so the earliest valid channel is assigned last.
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (v[idx]) gnt = SW'(idx);
    end
`ifdef RR_MUX_FORCE_EN
    if (force_en) begin
      forced  = 1'b1;
      gnt     = force_sel;
      gnt_vld = 1'b0;
      // Out-of-range force_sel matches no channel, so it yields no grant.
      for (int i = 0; i < N; i++) begin
        if (force_sel == SW'(i) && v[i]) gnt_vld = 1'b1;
      end
    end
`endif
  end

  // Capture qualification, one-hot taken pulse and granted-word mux.
  always_comb begin
    load     = ~reset & gnt_vld & (~y_vld | y_rdy);
    taken    = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      taken[i] = load & (gnt == SW'(i));
      if (gnt == SW'(i)) gnt_data = d[i*WIDTH +: WIDTH];
    end
    ptr_nxt = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
  end

  // Output register and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      y     <= '0;
      y_sel <= '0;
      y_vld <= 1'b0;
      ptr   <= '0;
    end else if (load) begin
      y     <= gnt_data;
      y_sel <= gnt;
      y_vld <= 1'b1;
      // Forced grants leave the round-robin order untouched.
      if (!forced) ptr <= ptr_nxt;
    end else if (y_rdy) begin
      y_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a 4-channel instance for the main sequence,
// backpressure, reset mid-transfer and (optionally) forced grants, plus a
// 3-channel instance for non-power-of-two pointer wrap.
module tb_rr_mux;

  logic        clk;
  logic        reset;
  logic [31:0] d4;
  logic [3:0]  v4;
  logic        rdy4;
  logic [3:0]  taken4;
  logic [7:0]  y4;
  logic        vld4;
  logic [1:0]  sel4;
`ifdef RR_MUX_FORCE_EN
  logic        force_en;
  logic [1:0]  force_sel;
  logic        force_en3;
  logic [1:0]  force_sel3;
`endif

  logic [23:0] d3;
  logic [2:0]  v3;
  logic        rdy3;
  logic [2:0]  taken3;
  logic [7:0]  y3;
  logic        vld3;
  logic [1:0]  sel3;

  int vecs;
  int errs;

  rr_mux #(.WIDTH(8), .N(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .d        (d4),
    .v        (v4),
`ifdef RR_MUX_FORCE_EN
    .force_en (force_en),
    .force_sel(force_sel),
`endif
    .taken    (taken4),
    .y        (y4),
    .y_vld    (vld4),
    .y_sel    (sel4),
    .y_rdy    (rdy4)
  );

  rr_mux #(.WIDTH(8), .N(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .d        (d3),
    .v        (v3),
`ifdef RR_MUX_FORCE_EN
    .force_en (force_en3),
    .force_sel(force_sel3),
`endif
    .taken    (taken3),
    .y        (y3),
    .y_vld    (vld3),
    .y_sel    (sel3),
    .y_rdy    (rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check registered outputs of the 4-channel instance.
  task automatic out4(input string tag, input logic vld, input logic [1:0] sel,
                      input logic [7:0] yv);
    check({tag, ".vld"}, {31'd0, vld4}, {31'd0, vld});
    check({tag, ".sel"}, {30'd0, sel4}, {30'd0, sel});
    check({tag, ".y"},   {24'd0, y4},   {24'd0, yv});
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    d4   = {8'h44, 8'h33, 8'h22, 8'h11};
    d3   = {8'hcc, 8'hbb, 8'haa};
    v4   = 4'hf;
    rdy4 = 1'b1;
    v3   = 3'b000;
    rdy3 = 1'b1;
`ifdef RR_MUX_FORCE_EN
    force_en   = 1'b0;
    force_sel  = 2'd0;
    force_en3  = 1'b0;
    force_sel3 = 2'd0;
`endif
    reset = 1'b1;

    // Reset held with every channel requesting.
    cyc();
    cyc();
    out4("rst", 1'b0, 2'd0, 8'h00);
    check("rst.taken", {28'd0, taken4}, 32'h0);

    // Release: first grant goes to channel 0 combinationally.
    reset = 1'b0;
    #1;
    check("rel.taken", {28'd0, taken4}, 32'h1);

    // Round-robin streaming with all channels valid.
    cyc(); out4("rr0", 1'b1, 2'd0, 8'h11); check("rr0.taken", {28'd0, taken4}, 32'h2);
    cyc(); out4("rr1", 1'b1, 2'd1, 8'h22); check("rr1.taken", {28'd0, taken4}, 32'h4);
    cyc(); out4("rr2", 1'b1, 2'd2, 8'h33); check("rr2.taken", {28'd0, taken4}, 32'h8);
    cyc(); out4("rr3", 1'b1, 2'd3, 8'h44); check("rr3.taken", {28'd0, taken4}, 32'h1);
    cyc(); out4("rr4", 1'b1, 2'd0, 8'h11);

    // Backpressure: word held, no grants; pointer is 1.
    rdy4 = 1'b0;
    #1;
    check("bp.taken", {28'd0, taken4}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      out4("bp", 1'b1, 2'd0, 8'h11);
      check("bp.taken_hold", {28'd0, taken4}, 32'h0);
    end
    rdy4 = 1'b1;
    #1;
    check("bp.resume_taken", {28'd0, taken4}, 32'h2);
    cyc(); out4("bp.resume", 1'b1, 2'd1, 8'h22);

    // Reset mid-transfer while output is full; pointer was 2.
    rdy4 = 1'b0;
    #1;
    check("mid.full_taken", {28'd0, taken4}, 32'h0);
    reset = 1'b1;
    #1;
    check("mid.rst_taken", {28'd0, taken4}, 32'h0);
    cyc();
    out4("mid.rst", 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    #1;
    check("mid.regrant", {28'd0, taken4}, 32'h1);
    cyc(); out4("mid.cap", 1'b1, 2'd0, 8'h11);

    // Idle bus: drain, then confirm the pointer did not rotate (still 1).
    v4   = 4'h0;
    rdy4 = 1'b1;
    #1;
    check("idle.taken", {28'd0, taken4}, 32'h0);
    cyc(); out4("idle.drain", 1'b0, 2'd0, 8'h11);
    cyc();
    v4 = 4'hf;
    #1;
    check("idle.next", {28'd0, taken4}, 32'h2);
    cyc(); out4("idle.cap", 1'b1, 2'd1, 8'h22);

`ifdef RR_MUX_FORCE_EN
    // Forced channel 0 repeatedly; pointer stays at 2.
    force_en  = 1'b1;
    force_sel = 2'd0;
    #1;
    check("frc.taken", {28'd0, taken4}, 32'h1);
    cyc(); out4("frc0", 1'b1, 2'd0, 8'h11);
    cyc(); out4("frc1", 1'b1, 2'd0, 8'h11);
    // Forced channel with no request: no grant.
    force_sel = 2'd3;
    v4        = 4'h7;
    #1;
    check("frc.novalid", {28'd0, taken4}, 32'h0);
    force_en = 1'b0;
    v4       = 4'hf;
    #1;
    check("frc.release", {28'd0, taken4}, 32'h4);
    cyc(); out4("frc.after", 1'b1, 2'd2, 8'h33);
`endif

    // Three channels, sparse requests on 0 and 2: pointer wraps 2 -> 0.
    v4 = 4'h0;
    v3 = 3'b101;
    #1;
    check("n3.t0", {29'd0, taken3}, 32'h1);
    cyc();
    check("n3.sel0", {30'd0, sel3}, 32'd0);
    check("n3.y0", {24'd0, y3}, 32'haa);
    check("n3.t1", {29'd0, taken3}, 32'h4);
    cyc();
    check("n3.sel2", {30'd0, sel3}, 32'd2);
    check("n3.y2", {24'd0, y3}, 32'hcc);
    check("n3.t2", {29'd0, taken3}, 32'h1);
    cyc();
    check("n3.sel0b", {30'd0, sel3}, 32'd0);
    check("n3.vld", {31'd0, vld3}, 32'd1);
    check("n3.t3", {29'd0, taken3}, 32'h4);
    cyc();
    check("n3.sel2b", {30'd0, sel3}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
